// File: rtl/dac_sample_fifo_if.sv
// Producer-to-FIFO valid/ready stream carrying unsigned DAC codes.
interface dac_sample_fifo_if #(
  parameter int DAC_BITS = 14
);
  logic                s_valid;
  logic                s_ready;
  logic [DAC_BITS-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/dac_sample_fifo.sv
// Sample FIFO feeding the R2R+PWM DAC core: primes to a fill level, then hands
// out one code per val_req, holding the last code and counting underruns when starved.
module dac_sample_fifo #(
  parameter int DAC_BITS    = 14,
  parameter int DEPTH       = 16,
  parameter int PRIME_LEVEL = 8,
  parameter int REPRIME     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  dac_sample_fifo_if.slave         s,
  input  logic                     val_req,
  output logic [DAC_BITS-1:0]      dac_val,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     running,
  output logic                     underrun,
  output logic [15:0]              underrun_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]         DEPTH_L  = (AW+1)'(DEPTH);
  localparam logic [AW:0]         PRIME_L  = (AW+1)'(PRIME_LEVEL);
  localparam logic [DAC_BITS-1:0] MIDSCALE = {1'b1, {(DAC_BITS-1){1'b0}}};

  typedef enum logic {PRIME, RUN} state_t;

  state_t              state_q, state_d;
  logic [AW:0]         wr_ptr_q, rd_ptr_q;
  logic [DAC_BITS-1:0] mem_q [DEPTH];
  logic [DAC_BITS-1:0] dac_val_q;
  logic                underrun_q, underrun_d;
  logic [15:0]         underrun_cnt_q;
  logic                full, empty, push, pop;
  logic [AW:0]         level_post;

  // Extra pointer bit distinguishes full from empty.
  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == DEPTH_L);
  assign empty = (level == '0);

  assign s.s_ready = !full;
  assign push      = s.s_valid && !full;
  assign pop       = (state_q == RUN) && val_req && !empty;
  assign underrun_d = (state_q == RUN) && val_req && empty;
  assign level_post = level + (AW+1)'(push) - (AW+1)'(pop);

  always_comb begin
    state_d = state_q;
    case (state_q)
      PRIME: if (level_post >= PRIME_L) state_d = RUN;
      RUN:   if (underrun_d && (REPRIME != 0)) state_d = PRIME;
      default: state_d = PRIME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= PRIME;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      dac_val_q      <= MIDSCALE;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      underrun_q <= underrun_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        dac_val_q <= mem_q[rd_ptr_q[AW-1:0]];
      end
      if (underrun_d && (underrun_cnt_q != '1))
        underrun_cnt_q <= underrun_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= s.s_data;
  end

  assign dac_val      = dac_val_q;
  assign running      = (state_q == RUN);
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;
endmodule

// File: tb/tb_dac_sample_fifo.sv
// Directed bench for dac_sample_fifo: stimulus queues expected per-request results,
// a monitor checks them after each val_req edge; a REPRIME=1 instance is checked directly.
module tb_dac_sample_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] dac;
    logic        und;
  } exp_t;

  exp_t sb_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  // Instance A: default parameters
  dac_sample_fifo_if #(.DAC_BITS(14)) bus_a ();
  logic        val_req_a = 1'b0;
  logic [13:0] dac_val_a;
  logic [4:0]  level_a;
  logic        running_a, underrun_a;
  logic [15:0] ucnt_a;

  dac_sample_fifo #(.DAC_BITS(14), .DEPTH(16), .PRIME_LEVEL(8), .REPRIME(0)) dut_a (
    .clk(clk), .rst(rst), .s(bus_a.slave), .val_req(val_req_a), .dac_val(dac_val_a),
    .level(level_a), .running(running_a), .underrun(underrun_a), .underrun_cnt(ucnt_a)
  );

  // Instance B: small FIFO, underrun re-primes
  dac_sample_fifo_if #(.DAC_BITS(14)) bus_b ();
  logic        val_req_b = 1'b0;
  logic [13:0] dac_val_b;
  logic [2:0]  level_b;
  logic        running_b, underrun_b;
  logic [15:0] ucnt_b;

  dac_sample_fifo #(.DAC_BITS(14), .DEPTH(4), .PRIME_LEVEL(2), .REPRIME(1)) dut_b (
    .clk(clk), .rst(rst), .s(bus_b.slave), .val_req(val_req_b), .dac_val(dac_val_b),
    .level(level_b), .running(running_b), .underrun(underrun_b), .underrun_cnt(ucnt_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [13:0] d);
    bus_a.s_valid = 1'b1;
    bus_a.s_data  = d;
    tick();
    bus_a.s_valid = 1'b0;
  endtask

  task automatic req_a(input logic [13:0] dac, input logic und);
    exp_t e;
    e.dac = dac;
    e.und = und;
    sb_q.push_back(e);
    val_req_a = 1'b1;
    tick();
    val_req_a = 1'b0;
  endtask

  task automatic push_b(input logic [13:0] d);
    bus_b.s_valid = 1'b1;
    bus_b.s_data  = d;
    tick();
    bus_b.s_valid = 1'b0;
  endtask

  task automatic req_b();
    val_req_b = 1'b1;
    tick();
    val_req_b = 1'b0;
  endtask

  // Monitor: every non-reset val_req edge on instance A yields one scoreboard entry
  always @(posedge clk) begin
    logic req_s, rst_s;
    exp_t e;
    req_s = val_req_a;
    rst_s = rst;
    #2;
    if (req_s && !rst_s) begin
      if (sb_q.size() == 0) begin
        total_cnt++;
        $display("FAIL sb_empty: got request with no expectation queued, expected 1 queued");
      end else begin
        e = sb_q.pop_front();
        chk("req_dac_val", 32'(dac_val_a), 32'(e.dac));
        chk("req_underrun", 32'(underrun_a), 32'(e.und));
      end
    end
  end

  initial begin
    bus_a.s_valid = 1'b0; bus_a.s_data = '0;
    bus_b.s_valid = 1'b0; bus_b.s_data = '0;

    // T1 reset
    tick(); tick();
    chk("rst_dac_val", 32'(dac_val_a), 32'h2000);
    chk("rst_level", 32'(level_a), 0);
    chk("rst_s_ready", 32'(bus_a.s_ready), 1);
    chk("rst_running", 32'(running_a), 0);
    chk("rst_ucnt", 32'(ucnt_a), 0);
    chk("rst_underrun", 32'(underrun_a), 0);
    rst = 1'b0;

    // T2 prime: requests ignored until PRIME_LEVEL entries
    for (int i = 1; i <= 7; i++) push_a(14'(i));
    req_a(14'h2000, 1'b0);
    chk("prime_level7", 32'(level_a), 7);
    chk("prime_running0", 32'(running_a), 0);
    push_a(14'd8);
    chk("prime_running1", 32'(running_a), 1);

    // T3 order/latency through a full FIFO
    for (int i = 9; i <= 16; i++) push_a(14'(i));
    chk("full_level", 32'(level_a), 16);
    chk("full_s_ready", 32'(bus_a.s_ready), 0);
    push_a(14'd99);
    chk("full_no_overflow", 32'(level_a), 16);
    req_a(14'd1, 1'b0);
    chk("after_pop_s_ready", 32'(bus_a.s_ready), 1);
    chk("after_pop_level", 32'(level_a), 15);
    for (int i = 2; i <= 16; i++) req_a(14'(i), 1'b0);
    chk("drained_level", 32'(level_a), 0);

    // T4 underrun holds last code
    for (int i = 0; i < 3; i++) req_a(14'd16, 1'b1);
    chk("ucnt3", 32'(ucnt_a), 3);
    chk("norepr_running", 32'(running_a), 1);
    tick();
    chk("underrun_one_clk", 32'(underrun_a), 0);
    chk("hold_dac_val", 32'(dac_val_a), 16);

    // T5 simultaneous push and pop
    for (int i = 20; i <= 23; i++) push_a(14'(i));
    bus_a.s_valid = 1'b1; bus_a.s_data = 14'd24;
    req_a(14'd20, 1'b0);
    bus_a.s_valid = 1'b0;
    chk("pushpop_level", 32'(level_a), 4);
    for (int i = 21; i <= 24; i++) req_a(14'(i), 1'b0);
    bus_a.s_valid = 1'b1; bus_a.s_data = 14'd30;
    req_a(14'd24, 1'b1);
    bus_a.s_valid = 1'b0;
    chk("empty_pushreq_level", 32'(level_a), 1);
    chk("empty_pushreq_ucnt", 32'(ucnt_a), 4);
    req_a(14'd30, 1'b0);

    // T6 reset mid-run with val_req high
    for (int i = 40; i <= 49; i++) push_a(14'(i));
    chk("pre_rst_level", 32'(level_a), 10);
    rst = 1'b1; val_req_a = 1'b1;
    tick();
    rst = 1'b0; val_req_a = 1'b0;
    chk("midrst_level", 32'(level_a), 0);
    chk("midrst_dac_val", 32'(dac_val_a), 32'h2000);
    chk("midrst_underrun", 32'(underrun_a), 0);
    chk("midrst_running", 32'(running_a), 0);
    chk("midrst_ucnt", 32'(ucnt_a), 0);

    // REPRIME=1 instance
    push_b(14'd5);
    chk("b_running0", 32'(running_b), 0);
    push_b(14'd6);
    chk("b_running1", 32'(running_b), 1);
    req_b();
    chk("b_pop5", 32'(dac_val_b), 5);
    req_b();
    chk("b_pop6", 32'(dac_val_b), 6);
    req_b();
    chk("b_underrun", 32'(underrun_b), 1);
    chk("b_reprime", 32'(running_b), 0);
    chk("b_hold", 32'(dac_val_b), 6);
    req_b();
    chk("b_prime_ignore_und", 32'(underrun_b), 0);
    chk("b_prime_ignore_cnt", 32'(ucnt_b), 1);
    push_b(14'd7);
    push_b(14'd8);
    chk("b_rerun", 32'(running_b), 1);
    req_b();
    chk("b_pop7", 32'(dac_val_b), 7);

    tick(); tick();
    chk("sb_drained", 32'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
